shared_alu_sched: RTL and testbench
===================================

SHARED_ALU_SCHED -- requirements
Module: shared_alu_sched

Interface
REQ-001 Reset SHALL be Rst, synchronous, active-high; clock SHALL be Clk.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand and result width.
REQ-003 Parameter CNT_W, default 8, SHALL set the job counter width.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Rst  in  1  synchronous active-high reset, highest priority.
REQ-006 Start  in  1  job request, sampled on the rising edge.
REQ-007 ErrorRst  in  1  clears the Error state.
REQ-008 a, b, c, d  in  WIDTH each  job operands, unsigned.
REQ-009 Busy  out  1  high in states CMP, ADD1, SEL and ADD2.
REQ-010 Done  out  1  high only in state DONE.
REQ-011 Error  out  1  high only in state ERR.
REQ-012 e, f  out  WIDTH each  registered results.
REQ-013 dLTe  out  1  registered comparison flag.
REQ-014 JobCnt  out  CNT_W  completed-job count.

Function
REQ-015 The block SHALL compute the schedule dLTe=(a<b); e=a+b; f=dLTe?c:d; if dLTe then e=b+c, using exactly one shared WIDTH-bit adder and one comparator, with at most one add per cycle.
REQ-016 States SHALL be IDLE, CMP, ADD1, SEL, ADD2, DONE and ERR.
REQ-017 In IDLE, Start=1 SHALL latch a, b, c and d into internal registers and go to CMP; Start=0 SHALL stay in IDLE.
REQ-018 CMP SHALL register dLTe = unsigned(a_l < b_l) and go to ADD1.
REQ-019 ADD1 SHALL register e = a_l + b_l and go to SEL.
REQ-020 SEL SHALL register f = dLTe ? c_l : d_l, then go to ADD2 if dLTe=1, else to DONE.
REQ-021 ADD2 SHALL register e = b_l + c_l and go to DONE.
REQ-022 Latency: if Start is sampled at edge k, Done SHALL be high in the cycle after edge k+3 when dLTe=0, and after edge k+4 when dLTe=1.
REQ-023 DONE SHALL last exactly one cycle.
REQ-024 On exit from DONE, JobCnt SHALL increment by 1 and wrap modulo 2^CNT_W.
REQ-025 Start=1 in DONE SHALL be accepted as a new job: latch operands and go to CMP, enabling back-to-back jobs.
REQ-026 Start=0 in DONE SHALL go to IDLE.
REQ-027 Start=1 while Busy SHALL go to ERR; the in-flight job SHALL be abandoned, e, f and dLTe SHALL hold, and JobCnt SHALL not increment.
REQ-028 In ERR, ErrorRst=1 SHALL go to IDLE, Start SHALL be ignored, and ErrorRst SHALL have no effect in any other state.
REQ-029 Additions SHALL wrap modulo 2^WIDTH with the carry discarded.
REQ-030 Input changes after the latch edge SHALL NOT affect the running job.
REQ-031 e, f and dLTe SHALL change only in the states that write them.

Reset
REQ-032 Rst=1 SHALL force state IDLE, Busy=0, Done=0, Error=0, e=0, f=0, dLTe=0, JobCnt=0 and clear the latched operands.
REQ-033 Rst SHALL override Start and ErrorRst in any state, including mid-job.

Verification
REQ-034 a=5, b=3, c=7, d=9, single Start pulse -> dLTe=0, e=8, f=9, Done 4 cycles after the Start edge, JobCnt=1.
REQ-035 a=2, b=10, c=4, d=1 -> dLTe=1, e=12 then 14, f=4, Done 5 cycles after the Start edge.
REQ-036 a=0xFFFF, b=0x0002 -> dLTe=0, e=0x0001 (wrap); then a=b=7 -> dLTe=0 (equal is not less-than).
REQ-037 Start re-pulsed in SEL -> Error=1 next cycle, outputs held, JobCnt unchanged; ErrorRst -> IDLE; Start then completes normally.
REQ-038 Start held high across DONE for two jobs -> no IDLE cycle between jobs, JobCnt advances by 2, second job uses operands present at its own latch edge.
REQ-039 Rst asserted in ADD1 -> next cycle all outputs 0 and state IDLE; Rst together with ErrorRst in ERR -> IDLE with Error=0.

Source files
------------

// File: rtl/shared_alu_sched.sv
// Multi-cycle job scheduler that evaluates dLTe=(a<b), e=a+b, f=dLTe?c:d and,
// when dLTe is set, e=b+c, all through one shared adder and one comparator.
module shared_alu_sched #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             ErrorRst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic             dLTe,
    output logic [CNT_W-1:0] JobCnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_ADD1, S_SEL, S_ADD2, S_DONE, S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic             latch_en, dlte_en, e_en, f_en, cnt_en, add_sel;
    logic [WIDTH-1:0] e_reg, f_reg;
    logic             dlte_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] op_in [4];
    logic [WIDTH-1:0] op_l  [4];
    logic [WIDTH-1:0] a_l, b_l, c_l, d_l;
    logic [WIDTH-1:0] add_x, add_y, sum;

    assign op_in[0] = a;
    assign op_in[1] = b;
    assign op_in[2] = c;
    assign op_in[3] = d;

    // Operands are captured once per job so later input changes cannot disturb it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_op
            logic [WIDTH-1:0] op_reg;
            always_ff @(posedge Clk) begin
                if (Rst)
                    op_reg <= '0;
                else if (latch_en)
                    op_reg <= op_in[gi];
            end
            assign op_l[gi] = op_reg;
        end
    endgenerate

    assign a_l = op_l[0];
    assign b_l = op_l[1];
    assign c_l = op_l[2];
    assign d_l = op_l[3];

    // Single shared adder: a+b in ADD1, b+c in ADD2; carry is dropped.
    assign add_x = add_sel ? b_l : a_l;
    assign add_y = add_sel ? c_l : b_l;
    assign sum   = add_x + add_y;

    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        dlte_en    = 1'b0;
        e_en       = 1'b0;
        f_en       = 1'b0;
        cnt_en     = 1'b0;
        add_sel    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    latch_en   = 1'b1;
                    state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (Start) state_next = S_ERR;
                else begin
                    dlte_en    = 1'b1;
                    state_next = S_ADD1;
                end
            end
            S_ADD1: begin
                if (Start) state_next = S_ERR;
                else begin
                    e_en       = 1'b1;
                    state_next = S_SEL;
                end
            end
            S_SEL: begin
                if (Start) state_next = S_ERR;
                else begin
                    f_en       = 1'b1;
                    state_next = dlte_reg ? S_ADD2 : S_DONE;
                end
            end
            S_ADD2: begin
                add_sel = 1'b1;
                if (Start) state_next = S_ERR;
                else begin
                    e_en       = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                cnt_en = 1'b1;
                if (Start) begin
                    latch_en   = 1'b1;
                    state_next = S_CMP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (ErrorRst) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= S_IDLE;
            e_reg     <= '0;
            f_reg     <= '0;
            dlte_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (dlte_en) dlte_reg <= (a_l < b_l);
            if (e_en)    e_reg    <= sum;
            if (f_en)    f_reg    <= dlte_reg ? c_l : d_l;
            if (cnt_en)  cnt_reg  <= cnt_reg + CNT_W'(1);
        end
    end

    assign Busy   = (state_reg == S_CMP) || (state_reg == S_ADD1) ||
                    (state_reg == S_SEL) || (state_reg == S_ADD2);
    assign Done   = (state_reg == S_DONE);
    assign Error  = (state_reg == S_ERR);
    assign e      = e_reg;
    assign f      = f_reg;
    assign dLTe   = dlte_reg;
    assign JobCnt = cnt_reg;

endmodule

// File: tb/tb_shared_alu_sched.sv
// Directed bench for shared_alu_sched: jobs are queued on a scoreboard at
// launch and checked when Done appears; error and reset paths are probed inline.
module tb_shared_alu_sched;

    localparam int W  = 16;
    localparam int CW = 3;

    logic          Clk, Rst, Start, ErrorRst;
    logic [W-1:0]  a, b, c, d;
    logic          Busy, Done, Error, dLTe;
    logic [W-1:0]  e, f;
    logic [CW-1:0] JobCnt;

    shared_alu_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ErrorRst(ErrorRst),
        .a(a), .b(b), .c(c), .d(d),
        .Busy(Busy), .Done(Done), .Error(Error),
        .e(e), .f(f), .dLTe(dLTe), .JobCnt(JobCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic         dlte;
        logic [W-1:0] e1;
        logic [W-1:0] e;
        logic [W-1:0] f;
        int           lat;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] model_cnt;
    logic [W-1:0]  last_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t ref_job(input logic [W-1:0] ra, rb, rc, rd);
        exp_t x;
        x.dlte = (ra < rb);
        x.e1   = ra + rb;
        x.e    = x.dlte ? W'(rb + rc) : x.e1;
        x.f    = x.dlte ? rc : rd;
        x.lat  = x.dlte ? 5 : 4;
        return x;
    endfunction

    task automatic drive_start(input logic [W-1:0] ra, rb, rc, rd);
        Start = 1'b1;
        a = ra; b = rb; c = rc; d = rd;
    endtask

    task automatic start_job(input logic [W-1:0] ra, rb, rc, rd, input exp_t x);
        drive_start(ra, rb, rc, rd);
        sb.push_back(x);
    endtask

    // Waits for Done; with chain=1 it returns on the Done cycle so the caller
    // can hold Start high for a back-to-back job.
    task automatic finish_job(input bit chain);
        exp_t x;
        int   n;
        bit   seen;
        x    = sb.pop_front();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                Start = 1'b0;
                a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
                check("busy_in_cmp", Busy, 1);
                check("jobcnt_running", JobCnt, model_cnt);
            end
            if (n == 3) begin
                check("dlte_mid", dLTe, x.dlte);
                check("e_after_add1", e, x.e1);
            end
            if (Done) seen = 1'b1;
        end
        check("done_latency", n, x.lat);
        check("e_final", e, x.e);
        check("f_final", f, x.f);
        check("dlte_final", dLTe, x.dlte);
        $display("job: dlte=%0d e=%0h f=%0h latency=%0d", dLTe, e, f, n);
        model_cnt = model_cnt + 1'b1;
        last_f    = x.f;
        if (!chain) begin
            @(negedge Clk);
            check("done_one_cycle", Done, 0);
            check("idle_not_busy", Busy, 0);
            check("jobcnt_after", JobCnt, model_cnt);
        end
    endtask

    initial begin
        exp_t x;
        logic [W-1:0] ra, rb, rc, rd;
        Rst = 1'b1; Start = 1'b0; ErrorRst = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        model_cnt = '0;
        last_f    = '0;

        repeat (2) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        check("rst_e", e, 0);
        check("rst_f", f, 0);
        check("rst_dlte", dLTe, 0);
        check("rst_jobcnt", JobCnt, 0);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_stays", Busy, 0);

        // Basic jobs, wraparound and equality
        start_job(16'd5, 16'd3, 16'd7, 16'd9, '{1'b0, 16'd8, 16'd8, 16'd9, 4});
        finish_job(1'b0);
        start_job(16'd2, 16'd10, 16'd4, 16'd1, '{1'b1, 16'd12, 16'd14, 16'd4, 5});
        finish_job(1'b0);
        start_job(16'hFFFF, 16'h0002, 16'd5, 16'd6, '{1'b0, 16'h0001, 16'h0001, 16'd6, 4});
        finish_job(1'b0);
        start_job(16'd7, 16'd7, 16'd1, 16'd2, '{1'b0, 16'd14, 16'd14, 16'd2, 4});
        finish_job(1'b0);

        // Back-to-back jobs with Start high on the DONE cycle
        start_job(16'd1, 16'd9, 16'd3, 16'd4, '{1'b1, 16'd10, 16'd12, 16'd3, 5});
        finish_job(1'b1);
        start_job(16'd8, 16'd4, 16'd2, 16'd6, '{1'b0, 16'd12, 16'd12, 16'd6, 4});
        finish_job(1'b0);

        // Start re-pulsed in SEL
        drive_start(16'd2, 16'd10, 16'd4, 16'd1);
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk);
        check("err_flag", Error, 1);
        check("err_busy", Busy, 0);
        check("err_e_held", e, 16'd12);
        check("err_f_held", f, last_f);
        check("err_dlte_held", dLTe, 1);
        check("err_jobcnt", JobCnt, model_cnt);
        @(negedge Clk);
        check("err_start_ignored", Error, 1);
        Start = 1'b0; ErrorRst = 1'b1;
        @(negedge Clk);
        ErrorRst = 1'b0;
        check("errrst_clears", Error, 0);
        check("errrst_idle", Busy, 0);
        start_job(16'd20, 16'd30, 16'd5, 16'd0, '{1'b1, 16'd50, 16'd35, 16'd5, 5});
        finish_job(1'b0);

        // Reset mid-job in ADD1
        drive_start(16'd5, 16'd3, 16'd7, 16'd9);
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_error", Error, 0);
        check("midrst_e", e, 0);
        check("midrst_f", f, 0);
        check("midrst_dlte", dLTe, 0);
        check("midrst_jobcnt", JobCnt, 0);
        Rst = 1'b0;
        model_cnt = '0;
        last_f    = '0;

        // Reset together with ErrorRst while in ERR
        drive_start(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge Clk);
        @(negedge Clk);
        check("err_from_cmp", Error, 1);
        Start = 1'b0; Rst = 1'b1; ErrorRst = 1'b1;
        @(negedge Clk);
        check("rst_errrst_error", Error, 0);
        check("rst_errrst_busy", Busy, 0);
        Rst = 1'b0; ErrorRst = 1'b0;

        // Random jobs, alternating chained and idle gaps; JobCnt wraps
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
            if (i % 3 == 0) rb = ra + W'(i);
            x = ref_job(ra, rb, rc, rd);
            start_job(ra, rb, rc, rd, x);
            finish_job(i % 2 == 0 && i != 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
